// File: rtl/snake_input_ctrl_if.sv
// rtl/snake_input_ctrl_if.sv - button input and step/direction outputs of the snake input stage
interface snake_input_ctrl_if;
   logic [3:0] btn_n;
   logic [1:0] move_direction;
   logic       step;
   logic       turn_pending;
   logic [3:0] btn_state;

   modport master (
      input  btn_n,
      output move_direction,
      output step,
      output turn_pending,
      output btn_state
   );

   modport slave (
      output btn_n,
      input  move_direction,
      input  step,
      input  turn_pending,
      input  btn_state
   );
endinterface

// File: rtl/snake_input_ctrl.sv
// rtl/snake_input_ctrl.sv - button conditioning, game-step tick and no-reversal direction commit
module snake_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int TICK_CYCLES     = 8000000
) (
   input  logic              clk,
   input  logic              reset,
   snake_input_ctrl_if.master bus
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int TW = $clog2(TICK_CYCLES);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [3:0]    stable;
   logic [DW-1:0] db_cnt [4];
   logic [3:0]    flip;
   logic [3:0]    press;
   logic          any_press;
   logic [1:0]    req_dir;

   logic [TW-1:0] tick_cnt;
   logic          wrap;
   logic [1:0]    dir;
   logic          step_q;
   logic [1:0]    pend_dir;
   logic          pend_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 4'hF;
         sync2 <= 4'hF;
      end else begin
         sync1 <= bus.btn_n;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable <= 4'hF;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= ~stable[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   // A press is the flip of a released (1) stable level, so it lands on the same edge as btn_state.
   always_comb begin
      flip = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         flip[i] = (sync2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
      end
      press     = flip & stable;
      any_press = |press;
      req_dir   = 2'd0;
      if (press[0])      req_dir = 2'd0;
      else if (press[1]) req_dir = 2'd1;
      else if (press[2]) req_dir = 2'd2;
      else if (press[3]) req_dir = 2'd3;
   end

   assign wrap = (tick_cnt == TICK_LAST);

   // Commit/discard of the old pending turn comes first; a press on the same edge reloads it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt   <= '0;
         step_q     <= 1'b0;
         dir        <= 2'd2;
         pend_dir   <= 2'd0;
         pend_valid <= 1'b0;
      end else begin
         tick_cnt <= wrap ? '0 : tick_cnt + TW'(1);
         step_q   <= wrap;
         if (wrap && pend_valid) begin
            if (pend_dir != (dir ^ 2'd2)) dir <= pend_dir;
            pend_valid <= 1'b0;
         end
         if (any_press) begin
            pend_dir   <= req_dir;
            pend_valid <= 1'b1;
         end
      end
   end

   assign bus.move_direction = dir;
   assign bus.step           = step_q;
   assign bus.turn_pending   = pend_valid;
   assign bus.btn_state      = ~stable;
endmodule

// File: tb/tb_snake_input_ctrl.sv
// tb/tb_snake_input_ctrl.sv - directed scoreboard bench for snake_input_ctrl
module tb_snake_input_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   edges = 0;

   typedef struct packed {
      logic [1:0] dir;
      logic       pend;
   } exp_t;
   exp_t sb[$];

   snake_input_ctrl_if bus ();

   snake_input_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic align(input int k);
      int n = 0;
      while ((edges % 16) != k && n < 40) begin
         cyc(1);
         n++;
      end
   endtask

   task automatic wait_step(input string tag);
      exp_t e;
      int   n = 0;
      cyc(1);
      while (bus.step !== 1'b1 && n < 40) begin
         cyc(1);
         n++;
      end
      e = sb.pop_front();
      chk({tag, "_step_seen"}, {7'd0, bus.step}, 8'd1);
      chk({tag, "_dir"}, {6'd0, bus.move_direction}, {6'd0, e.dir});
      chk({tag, "_pend"}, {7'd0, bus.turn_pending}, {7'd0, e.pend});
   endtask

   task automatic press_pulse(input string tag, input logic [3:0] mask);
      align(1);
      bus.btn_n = ~mask;
      cyc(6);
      chk({tag, "_btn_state"}, {4'd0, bus.btn_state}, {4'd0, mask});
      chk({tag, "_pending"}, {7'd0, bus.turn_pending}, 8'd1);
      bus.btn_n = 4'hF;
   endtask

   task automatic first_steps(input string tag);
      logic early = 1'b0;
      for (int k = 1; k < 16; k++) begin
         cyc(1);
         if (bus.step !== 1'b0) early = 1'b1;
      end
      chk({tag, "_step_early"}, {7'd0, early}, 8'd0);
      cyc(1);
      chk({tag, "_step16"}, {7'd0, bus.step}, 8'd1);
      chk({tag, "_dir16"}, {6'd0, bus.move_direction}, 8'd2);
      cyc(1);
      chk({tag, "_step17"}, {7'd0, bus.step}, 8'd0);
      cyc(15);
      chk({tag, "_step32"}, {7'd0, bus.step}, 8'd1);
   endtask

   initial begin
      bus.btn_n = 4'hF;
      reset = 1'b0;
      cyc(3);
      chk("rst_dir", {6'd0, bus.move_direction}, 8'd2);
      chk("rst_step", {7'd0, bus.step}, 8'd0);
      chk("rst_pend", {7'd0, bus.turn_pending}, 8'd0);
      chk("rst_btn", {4'd0, bus.btn_state}, 8'd0);
      reset = 1'b1;
      edges = 0;
      first_steps("s1");

      align(1);
      bus.btn_n = 4'b1101;
      cyc(3);
      bus.btn_n = 4'hF;
      cyc(8);
      chk("glitch_btn", {4'd0, bus.btn_state}, 8'd0);
      chk("glitch_pend", {7'd0, bus.turn_pending}, 8'd0);

      align(1);
      bus.btn_n = 4'b1101;
      cyc(5);
      chk("up_btn_e4", {4'd0, bus.btn_state}, 8'd0);
      chk("up_pend_e4", {7'd0, bus.turn_pending}, 8'd0);
      cyc(1);
      chk("up_btn_e5", {4'd0, bus.btn_state}, 8'b0010);
      chk("up_pend_e5", {7'd0, bus.turn_pending}, 8'd1);
      bus.btn_n = 4'hF;
      sb.push_back('{dir: 2'd1, pend: 1'b0});
      wait_step("s2");

      press_pulse("right", 4'b0100);
      sb.push_back('{dir: 2'd2, pend: 1'b0});
      wait_step("s3a");
      press_pulse("left", 4'b0001);
      sb.push_back('{dir: 2'd2, pend: 1'b0});
      wait_step("s3b");

      align(1);
      bus.btn_n = 4'b1101;
      cyc(6);
      bus.btn_n = 4'b0111;
      cyc(6);
      chk("s4_down_btn", {4'd0, bus.btn_state}, 8'b1000);
      bus.btn_n = 4'hF;
      sb.push_back('{dir: 2'd3, pend: 1'b0});
      wait_step("s4a");
      press_pulse("right2", 4'b0100);
      sb.push_back('{dir: 2'd2, pend: 1'b0});
      wait_step("s4b");
      press_pulse("all4", 4'b1111);
      sb.push_back('{dir: 2'd2, pend: 1'b0});
      wait_step("s4c");

      align(1);
      bus.btn_n = 4'b1101;
      cyc(6);
      bus.btn_n = 4'hF;
      align(10);
      bus.btn_n = 4'b0111;
      cyc(5);
      chk("s5_down_early", {4'd0, bus.btn_state}, 8'd0);
      chk("s5_pend_up", {7'd0, bus.turn_pending}, 8'd1);
      sb.push_back('{dir: 2'd1, pend: 1'b1});
      wait_step("s5a");
      chk("s5_down_btn", {4'd0, bus.btn_state}, 8'b1000);
      bus.btn_n = 4'hF;
      sb.push_back('{dir: 2'd1, pend: 1'b0});
      wait_step("s5b");

      align(1);
      bus.btn_n = 4'b1110;
      cyc(6);
      chk("s6_pend", {7'd0, bus.turn_pending}, 8'd1);
      bus.btn_n = 4'b1100;
      cyc(2);
      #2;
      reset = 1'b0;
      #1;
      chk("s6_rst_dir", {6'd0, bus.move_direction}, 8'd2);
      chk("s6_rst_pend", {7'd0, bus.turn_pending}, 8'd0);
      chk("s6_rst_btn", {4'd0, bus.btn_state}, 8'd0);
      chk("s6_rst_step", {7'd0, bus.step}, 8'd0);
      bus.btn_n = 4'hF;
      cyc(3);
      reset = 1'b1;
      edges = 0;
      first_steps("s6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
